ps2_key_tracker: RTL and testbench

Upstream feeder for the hex seven-segment decoders in the keyboard display path. Receives raw PS/2 frames and validates them (start, odd parity, stop). Tracks make/break codes with a small FSM and presents three values to the display top, which splits them into nibbles, one hex decoder per nibble:
- the current scan code
- a key-press counter
- a key-active flag, which drives display blanking

---
 rtl/ps2_key_tracker.sv | 144 ++++++++++++++
 tb/tb_ps2_key_tracker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: synchronises the raw PS/2 lines, validates 11-bit frames
// and tracks make/break codes to drive the hex display path.
module ps2_key_tracker #(
  parameter int TIMEOUT = 5000,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [7:0]       scan_code,
  output logic [CNT_W-1:0] key_count,
  output logic             key_active,
  output logic             frame_err,
  output logic             byte_valid
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, BRK} state_t;

  logic [2:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             fe;
  logic             data_s;
  logic [9:0]       shift_reg;
  logic [3:0]       bitcnt;
  logic [TW-1:0]    tcnt;
  logic [7:0]       rx_byte;
  logic             frame_ok;
  state_t           state, state_nx;
  logic [7:0]       scan_nx;
  logic [CNT_W-1:0] count_nx;
  logic             active_nx;

  // Data chain is one flop shorter so its output lines up with clk_sync[1].
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign fe     = clk_sync[2] & ~clk_sync[1];
  assign data_s = data_sync[1];

  // shift_reg holds start (bit 0), data (8:1) and parity (9) when the stop bit arrives.
  assign frame_ok = ~shift_reg[0] & data_s & (^shift_reg[9:1]);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      shift_reg  <= '0;
      bitcnt     <= '0;
      tcnt       <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fe) begin
        tcnt <= '0;
        if (bitcnt == 4'd10) begin
          bitcnt <= '0;
          if (frame_ok) begin
            byte_valid <= 1'b1;
            rx_byte    <= shift_reg[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          shift_reg <= {data_s, shift_reg[9:1]};
          bitcnt    <= bitcnt + 4'd1;
        end
      end else if (bitcnt != 4'd0) begin
        // A stalled frame is silently dropped so the next start bit realigns.
        if (tcnt == T_LAST) begin
          bitcnt <= '0;
          tcnt   <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      scan_code  <= '0;
      key_count  <= '0;
      key_active <= 1'b0;
    end else begin
      state      <= state_nx;
      scan_code  <= scan_nx;
      key_count  <= count_nx;
      key_active <= active_nx;
    end
  end

  // The decoder only moves on the cycle a validated byte is presented.
  always_comb begin
    state_nx  = state;
    scan_nx   = scan_code;
    count_nx  = key_count;
    active_nx = key_active;
    if (byte_valid) begin
      case (state)
        IDLE: begin
          if (rx_byte == 8'hF0) begin
            state_nx = BRK;
          end else begin
            scan_nx   = rx_byte;
            active_nx = 1'b1;
            count_nx  = key_count + CNT_W'(1);
            state_nx  = PRESSED;
          end
        end
        PRESSED: begin
          if (rx_byte == 8'hF0) begin
            state_nx = BRK;
          end else if (rx_byte != scan_code) begin
            scan_nx  = rx_byte;
            count_nx = key_count + CNT_W'(1);
          end
        end
        BRK: begin
          if (rx_byte == scan_code && key_active) begin
            active_nx = 1'b0;
            state_nx  = IDLE;
          end else begin
            state_nx = key_active ? PRESSED : IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: drives PS/2 frames and compares the
// outputs with a key-tracking model kept in the bench.
module tb_ps2_key_tracker;

  localparam int TIMEOUT = 5000;
  localparam int CNT_W   = 8;
  localparam int HALF    = 4;

  logic             clk = 1'b0;
  logic             clrn = 1'b0;
  logic             ps2_clk = 1'b1;
  logic             ps2_data = 1'b1;
  logic [7:0]       scan_code;
  logic [CNT_W-1:0] key_count;
  logic             key_active;
  logic             frame_err;
  logic             byte_valid;

  int checks = 0;
  int errors = 0;
  int bv_pulses = 0;
  int fe_pulses = 0;

  logic [7:0]       m_scan = '0;
  logic [CNT_W-1:0] m_count = '0;
  logic             m_active = 1'b0;
  logic             m_brk = 1'b0;

  ps2_key_tracker #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .key_count  (key_count),
    .key_active (key_active),
    .frame_err  (frame_err),
    .byte_valid (byte_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid === 1'b1) bv_pulses++;
    if (frame_err === 1'b1) fe_pulses++;
  end

  task automatic model_reset();
    m_scan = '0; m_count = '0; m_active = 1'b0; m_brk = 1'b0;
  endtask

  // Key semantics: F0 announces a release; the following byte releases the held key if it matches.
  task automatic model_byte(input logic [7:0] b);
    if (m_brk) begin
      m_brk = 1'b0;
      if (b == m_scan && m_active) m_active = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (!m_active || b != m_scan) begin
      m_scan = b;
      m_active = 1'b1;
      m_count = m_count + 1'b1;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input logic par_flip, input logic stop, input int nbits);
    logic [10:0] fr;
    fr = {stop, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk) ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_key(input logic [7:0] b);
    send_bits(b, 1'b0, 1'b1, 11);
    model_byte(b);
  endtask

  task automatic test_reset();
    @(negedge clk) clrn = 1'b0;
    #1;
    checks++; if (scan_code !== 8'h00) begin errors++; $display("[TB] FAIL reset_scan: got %h expected 00", scan_code); end
    checks++; if (key_count !== '0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", key_count); end
    checks++; if (key_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %b expected 0", key_active); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr: got %b expected 0", frame_err); end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_bv: got %b expected 0", byte_valid); end
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_key();
    int bv0;
    bv0 = bv_pulses;
    send_key(8'h1C);
    checks++; if (bv_pulses - bv0 !== 1) begin errors++; $display("[TB] FAIL single_bv: got %0d pulses expected 1", bv_pulses - bv0); end
    checks++; if (scan_code !== 8'h1C) begin errors++; $display("[TB] FAIL single_scan: got %h expected 1c", scan_code); end
    checks++; if (key_active !== 1'b1) begin errors++; $display("[TB] FAIL single_active: got %b expected 1", key_active); end
    checks++; if (key_count !== 8'd1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", key_count); end
  endtask

  task automatic test_typematic();
    for (int i = 0; i < 3; i++) send_key(8'h1C);
    checks++; if (scan_code !== 8'h1C) begin errors++; $display("[TB] FAIL repeat_scan: got %h expected 1c", scan_code); end
    checks++; if (key_count !== 8'd1) begin errors++; $display("[TB] FAIL repeat_count: got %0d expected 1", key_count); end
    checks++; if (key_active !== 1'b1) begin errors++; $display("[TB] FAIL repeat_active: got %b expected 1", key_active); end
  endtask

  task automatic test_release();
    send_key(8'hF0);
    send_key(8'h1C);
    checks++; if (key_active !== 1'b0) begin errors++; $display("[TB] FAIL release_active: got %b expected 0", key_active); end
    checks++; if (scan_code !== 8'h1C) begin errors++; $display("[TB] FAIL release_scan: got %h expected 1c", scan_code); end
    send_key(8'h32);
    checks++; if (scan_code !== 8'h32) begin errors++; $display("[TB] FAIL repress_scan: got %h expected 32", scan_code); end
    checks++; if (key_count !== 8'd2) begin errors++; $display("[TB] FAIL repress_count: got %0d expected 2", key_count); end
    checks++; if (key_active !== 1'b1) begin errors++; $display("[TB] FAIL repress_active: got %b expected 1", key_active); end
  endtask

  task automatic test_corrupt();
    int fe0, bv0;
    fe0 = fe_pulses; bv0 = bv_pulses;
    send_bits(8'h1C, 1'b1, 1'b1, 11);
    checks++; if (fe_pulses - fe0 !== 1) begin errors++; $display("[TB] FAIL parity_ferr: got %0d pulses expected 1", fe_pulses - fe0); end
    send_bits(8'h1C, 1'b0, 1'b0, 11);
    checks++; if (fe_pulses - fe0 !== 2) begin errors++; $display("[TB] FAIL stop_ferr: got %0d pulses expected 2", fe_pulses - fe0); end
    checks++; if (bv_pulses - bv0 !== 0) begin errors++; $display("[TB] FAIL corrupt_bv: got %0d pulses expected 0", bv_pulses - bv0); end
    checks++; if (scan_code !== m_scan) begin errors++; $display("[TB] FAIL corrupt_scan: got %h expected %h", scan_code, m_scan); end
    checks++; if (key_count !== m_count) begin errors++; $display("[TB] FAIL corrupt_count: got %0d expected %0d", key_count, m_count); end
  endtask

  task automatic test_timeout();
    int fe0;
    fe0 = fe_pulses;
    send_bits(8'h77, 1'b0, 1'b1, 5);
    repeat (TIMEOUT + 10) @(negedge clk);
    send_key(8'h45);
    checks++; if (scan_code !== 8'h45) begin errors++; $display("[TB] FAIL timeout_scan: got %h expected 45", scan_code); end
    checks++; if (fe_pulses - fe0 !== 0) begin errors++; $display("[TB] FAIL timeout_ferr: got %0d pulses expected 0", fe_pulses - fe0); end
    checks++; if (key_count !== m_count) begin errors++; $display("[TB] FAIL timeout_count: got %0d expected %0d", key_count, m_count); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int bv0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: b = 8'hF0;
        1: b = 8'h1C;
        2: b = 8'h32;
        3: b = 8'h45;
        default: b = 8'hE0;
      endcase
      bv0 = bv_pulses;
      send_key(b);
      checks++; if (bv_pulses - bv0 !== 1) begin errors++; $display("[TB] FAIL rand_bv[%0d]: got %0d expected 1", i, bv_pulses - bv0); end
      checks++; if (scan_code !== m_scan) begin errors++; $display("[TB] FAIL rand_scan[%0d]: byte %h got %h expected %h", i, b, scan_code, m_scan); end
      checks++; if (key_active !== m_active) begin errors++; $display("[TB] FAIL rand_active[%0d]: byte %h got %b expected %b", i, b, key_active, m_active); end
      checks++; if (key_count !== m_count) begin errors++; $display("[TB] FAIL rand_count[%0d]: byte %h got %0d expected %0d", i, b, key_count, m_count); end
    end
    if (m_brk) send_key(8'h11);
  endtask

  task automatic test_wrap();
    logic [7:0] k;
    logic [CNT_W-1:0] start;
    start = m_count;
    for (int n = 0; n < (1 << CNT_W); n++) begin
      k = 8'($urandom_range(1, 8'hEF));
      while (m_active && k == m_scan) k = 8'($urandom_range(1, 8'hEF));
      send_key(k);
      if ($urandom_range(0, 3) == 0) begin
        send_key(8'hF0);
        send_key(k);
      end
      checks++; if (key_count !== m_count) begin errors++; $display("[TB] FAIL wrap_count[%0d]: got %0d expected %0d", n, key_count, m_count); end
    end
    checks++; if (key_count !== start) begin errors++; $display("[TB] FAIL wrap_final: got %0d expected %0d", key_count, start); end
    checks++; if (key_active !== m_active) begin errors++; $display("[TB] FAIL wrap_active: got %b expected %b", key_active, m_active); end
  endtask

  task automatic test_reset_midframe();
    int fe0;
    send_key(8'h5A);
    send_bits(8'h2B, 1'b0, 1'b1, 5);
    @(negedge clk) clrn = 1'b0;
    #1;
    checks++; if (scan_code !== 8'h00) begin errors++; $display("[TB] FAIL midrst_scan: got %h expected 00", scan_code); end
    checks++; if (key_count !== '0) begin errors++; $display("[TB] FAIL midrst_count: got %0d expected 0", key_count); end
    checks++; if (key_active !== 1'b0) begin errors++; $display("[TB] FAIL midrst_active: got %b expected 0", key_active); end
    model_reset();
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (5) @(negedge clk);
    fe0 = fe_pulses;
    send_key(8'h4D);
    checks++; if (scan_code !== 8'h4D) begin errors++; $display("[TB] FAIL postrst_scan: got %h expected 4d", scan_code); end
    checks++; if (key_count !== 8'd1) begin errors++; $display("[TB] FAIL postrst_count: got %0d expected 1", key_count); end
    checks++; if (key_active !== 1'b1) begin errors++; $display("[TB] FAIL postrst_active: got %b expected 1", key_active); end
    checks++; if (fe_pulses - fe0 !== 0) begin errors++; $display("[TB] FAIL postrst_ferr: got %0d pulses expected 0", fe_pulses - fe0); end
  endtask

  initial begin
    $display("[TB] ps2_key_tracker bench start");
    test_reset();
    test_single_key();
    test_typematic();
    test_release();
    test_corrupt();
    test_timeout();
    test_random();
    test_wrap();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
